// File: rtl/uop_cache_ctrl_if.sv
// Bus bundle between the uop-cache controller, the loop detector, fetch and the BRAM.
// The slave modport is the controller's view; master is the surrounding logic's view.
interface uop_cache_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              fill_start;
    logic              fill_valid;
    logic [DATA_W-1:0] fill_instr;
    logic              fill_last;
    logic              fill_ready;
    logic              replay_req;
    logic              replay_valid;
    logic [DATA_W-1:0] replay_instr;
    logic              replay_wrap;
    logic              flush;
    logic              bram_we;
    logic              bram_re;
    logic [ADDR_W-1:0] bram_waddr;
    logic [ADDR_W-1:0] bram_raddr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              loop_valid;
    logic [4:0]        loop_len;
    logic [15:0]       iter_cnt;
    logic              overflow_err;

    modport slave (
        input  fill_start, fill_valid, fill_instr, fill_last,
        input  replay_req, flush, bram_rdata,
        output fill_ready, replay_valid, replay_instr, replay_wrap,
        output bram_we, bram_re, bram_waddr, bram_raddr, bram_wdata,
        output loop_valid, loop_len, iter_cnt, overflow_err
    );

    modport master (
        output fill_start, fill_valid, fill_instr, fill_last,
        output replay_req, flush, bram_rdata,
        input  fill_ready, replay_valid, replay_instr, replay_wrap,
        input  bram_we, bram_re, bram_waddr, bram_raddr, bram_wdata,
        input  loop_valid, loop_len, iter_cnt, overflow_err
    );
endinterface

// File: rtl/uop_cache_ctrl.sv
// Loop uop-cache sequencer: fills the BRAM with a captured loop body and replays it
// to fetch, wrapping at the loop end and counting completed iterations.
module uop_cache_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter int STRIDE = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    uop_cache_ctrl_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_READY  = 3'd2,
        ST_REPLAY = 3'd3,
        ST_INVAL  = 3'd4
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [4:0]       r_loop_len;
    logic [15:0]      r_iter_cnt;

    state_t           w_state_nxt;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [4:0]       w_loop_len_nxt;
    logic [15:0]      w_iter_nxt;
    logic             w_we;
    logic             w_re;
    logic [PTR_W-1:0] w_ridx;
    logic             w_wrap;
    logic             w_ovf;
    logic             w_fill_ready;
    logic             w_replay_valid;
    logic             w_last_idx;

    function automatic logic [ADDR_W-1:0] idx2addr(input logic [PTR_W-1:0] idx);
        logic [31:0] prod;
        prod = 32'(idx) * 32'(STRIDE);
        return prod[ADDR_W-1:0];
    endfunction

    assign w_last_idx = (5'(r_rptr) == (r_loop_len - 5'd1));

    // Next-state and control decode; flush overrides every state.
    always_comb begin
        w_state_nxt    = r_state;
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        w_loop_len_nxt = r_loop_len;
        w_iter_nxt     = r_iter_cnt;
        w_we           = 1'b0;
        w_re           = 1'b0;
        w_ridx         = r_rptr;
        w_wrap         = 1'b0;
        w_ovf          = 1'b0;
        w_fill_ready   = 1'b0;
        w_replay_valid = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_INVAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fill_start) begin
                        w_state_nxt = ST_FILL;
                        w_wptr_nxt  = {PTR_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    w_fill_ready = 1'b1;
                    if (bus.fill_valid) begin
                        if (r_wptr < DEPTH_P) begin
                            w_we       = 1'b1;
                            w_wptr_nxt = r_wptr + {{(PTR_W-1){1'b0}}, 1'b1};
                            if (bus.fill_last) begin
                                w_loop_len_nxt = 5'(r_wptr) + 5'd1;
                                w_rptr_nxt     = {PTR_W{1'b0}};
                                w_iter_nxt     = 16'd0;
                                w_state_nxt    = ST_READY;
                            end else begin
                                w_state_nxt = ST_FILL;
                            end
                        end else begin
                            // Body longer than the cache: drop it and wait for a new capture.
                            w_ovf       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_READY: begin
                    if (bus.replay_req) begin
                        w_re        = 1'b1;
                        w_ridx      = r_rptr;
                        w_state_nxt = ST_REPLAY;
                    end else begin
                        w_state_nxt = ST_READY;
                    end
                end
                ST_REPLAY: begin
                    w_replay_valid = 1'b1;
                    if (bus.replay_req) begin
                        if (w_last_idx) begin
                            w_rptr_nxt = {PTR_W{1'b0}};
                            w_wrap     = 1'b1;
                            if (r_iter_cnt != 16'hFFFF) begin
                                w_iter_nxt = r_iter_cnt + 16'd1;
                            end else begin
                                w_iter_nxt = r_iter_cnt;
                            end
                        end else begin
                            w_rptr_nxt = r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
                        end
                        // Prefetch the following entry so fetch sees one instr per cycle.
                        w_re        = 1'b1;
                        w_ridx      = w_rptr_nxt;
                        w_state_nxt = ST_REPLAY;
                    end else begin
                        w_state_nxt = ST_READY;
                    end
                end
                ST_INVAL: begin
                    w_wptr_nxt     = {PTR_W{1'b0}};
                    w_rptr_nxt     = {PTR_W{1'b0}};
                    w_loop_len_nxt = 5'd0;
                    w_iter_nxt     = 16'd0;
                    w_state_nxt    = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_INVAL;
                end
            endcase
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wptr     <= {PTR_W{1'b0}};
            r_rptr     <= {PTR_W{1'b0}};
            r_loop_len <= 5'd0;
            r_iter_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_loop_len <= w_loop_len_nxt;
            r_iter_cnt <= w_iter_nxt;
        end
    end

    assign bus.fill_ready   = w_fill_ready;
    assign bus.bram_we      = w_we;
    assign bus.bram_re      = w_re;
    assign bus.bram_waddr   = w_we ? idx2addr(r_wptr) : {ADDR_W{1'b0}};
    assign bus.bram_raddr   = w_re ? idx2addr(w_ridx) : {ADDR_W{1'b0}};
    assign bus.bram_wdata   = w_we ? bus.fill_instr : {DATA_W{1'b0}};
    assign bus.replay_valid = w_replay_valid;
    assign bus.replay_instr = w_replay_valid ? bus.bram_rdata : {DATA_W{1'b0}};
    assign bus.replay_wrap  = w_wrap;
    assign bus.overflow_err = w_ovf;
    assign bus.loop_valid   = (r_state == ST_READY) || (r_state == ST_REPLAY);
    assign bus.loop_len     = r_loop_len;
    assign bus.iter_cnt     = r_iter_cnt;
endmodule

// File: tb/tb_uop_cache_ctrl.sv
// Directed bench for uop_cache_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_uop_cache_ctrl;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    logic [31:0] mem [64];
    logic [31:0] body [3];

    uop_cache_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    uop_cache_ctrl #(.DEPTH(8), .ADDR_W(6), .STRIDE(8), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM stand-in: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_waddr] <= bus.bram_wdata;
        if (bus.bram_re) bus.bram_rdata <= mem[bus.bram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        body[0] = 32'hA000_000A;
        body[1] = 32'hB000_000B;
        body[2] = 32'hC000_000C;
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b0;
        bus.fill_instr = 32'd0;
        bus.fill_last  = 1'b0;
        bus.replay_req = 1'b0;
        bus.flush      = 1'b0;
        bus.bram_rdata = 32'd0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("rst_loop_valid", 32'(bus.loop_valid), 32'd0);
        chk("rst_loop_len", 32'(bus.loop_len), 32'd0);
        chk("rst_iter", 32'(bus.iter_cnt), 32'd0);
        chk("rst_replay_valid", 32'(bus.replay_valid), 32'd0);
        chk("rst_we_re", 32'({bus.bram_we, bus.bram_re}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill A,B,C then replay 7 instructions
        bus.fill_start = 1'b1;
        #1 chk("idle_fill_ready", 32'(bus.fill_ready), 32'd0);
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fill_instr = body[i];
            bus.fill_last  = (i == 2);
            #1;
            chk("fill_we", 32'(bus.bram_we), 32'd1);
            chk("fill_waddr", 32'(bus.bram_waddr), 32'(i * 8));
            chk("fill_wdata", bus.bram_wdata, body[i]);
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
        #1;
        chk("ready_loop_valid", 32'(bus.loop_valid), 32'd1);
        chk("ready_loop_len", 32'(bus.loop_len), 32'd3);
        chk("ready_replay_valid", 32'(bus.replay_valid), 32'd0);
        bus.replay_req = 1'b1;
        #1;
        chk("ready_re", 32'(bus.bram_re), 32'd1);
        chk("ready_raddr", 32'(bus.bram_raddr), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("rp_valid", 32'(bus.replay_valid), 32'd1);
            chk("rp_instr", bus.replay_instr, body[k % 3]);
            chk("rp_wrap", 32'(bus.replay_wrap), (k % 3 == 2) ? 32'd1 : 32'd0);
            chk("rp_raddr", 32'(bus.bram_raddr), 32'(((k + 1) % 3) * 8));
            chk("rp_no_we", 32'(bus.bram_we), 32'd0);
            @(negedge clk);
        end
        #1 chk("iter_after_7", 32'(bus.iter_cnt), 32'd2);

        // Drop replay_req two cycles, then resume at the unconsumed entry
        bus.replay_req = 1'b0;
        #1;
        chk("hold_valid", 32'(bus.replay_valid), 32'd1);
        chk("hold_instr", bus.replay_instr, body[1]);
        chk("hold_re", 32'(bus.bram_re), 32'd0);
        @(negedge clk);
        #1 chk("drop_valid", 32'(bus.replay_valid), 32'd0);
        @(negedge clk);
        bus.replay_req = 1'b1;
        #1 chk("resume_raddr", 32'(bus.bram_raddr), 32'd8);
        @(negedge clk);
        #1 chk("resume_b", bus.replay_instr, body[1]);
        @(negedge clk);
        #1;
        chk("resume_c", bus.replay_instr, body[2]);
        chk("resume_c_wrap", 32'(bus.replay_wrap), 32'd1);
        @(negedge clk);
        #1;
        chk("resume_a", bus.replay_instr, body[0]);
        chk("iter_3", 32'(bus.iter_cnt), 32'd3);
        bus.replay_req = 1'b0;
        @(negedge clk);

        // flush and fill_start together in READY: no FILL entered
        bus.fill_start = 1'b1;
        bus.flush      = 1'b1;
        bus.fill_valid = 1'b1;
        bus.fill_instr = 32'hDEAD_0001;
        #1 chk("ff_we", 32'(bus.bram_we), 32'd0);
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.flush      = 1'b0;
        #1;
        chk("inval_loop_valid", 32'(bus.loop_valid), 32'd0);
        chk("inval_we", 32'(bus.bram_we), 32'd0);
        chk("inval_fill_ready", 32'(bus.fill_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("post_inval_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("post_inval_we", 32'(bus.bram_we), 32'd0);
        chk("post_inval_len", 32'(bus.loop_len), 32'd0);
        chk("post_inval_iter", 32'(bus.iter_cnt), 32'd0);
        bus.fill_valid = 1'b0;
        @(negedge clk);

        // flush on the second fill beat
        bus.fill_start = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_instr = body[0];
        #1 chk("fl_beat1_we", 32'(bus.bram_we), 32'd1);
        @(negedge clk);
        bus.fill_instr = body[1];
        bus.flush      = 1'b1;
        #1 chk("fl_beat2_we", 32'(bus.bram_we), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("fl_inval_we", 32'(bus.bram_we), 32'd0);
        chk("fl_inval_valid", 32'(bus.loop_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("fl_idle_we", 32'(bus.bram_we), 32'd0);
        chk("fl_idle_ready", 32'(bus.fill_ready), 32'd0);
        bus.fill_valid = 1'b0;
        @(negedge clk);

        // 9-beat body with DEPTH=8 overflows
        bus.fill_start = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.fill_instr = 32'h0000_0100 + 32'(i);
            #1;
            if (i < 8) begin
                chk("ov_we", 32'(bus.bram_we), 32'd1);
                chk("ov_waddr", 32'(bus.bram_waddr), 32'(i * 8));
                chk("ov_err_early", 32'(bus.overflow_err), 32'd0);
            end else begin
                chk("ov_we_9th", 32'(bus.bram_we), 32'd0);
                chk("ov_err", 32'(bus.overflow_err), 32'd1);
            end
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        #1;
        chk("ov_err_pulse", 32'(bus.overflow_err), 32'd0);
        chk("ov_idle_ready", 32'(bus.fill_ready), 32'd0);
        chk("ov_loop_valid", 32'(bus.loop_valid), 32'd0);
        @(negedge clk);

        // Single-entry loop wraps on every consume
        bus.fill_start = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_last  = 1'b1;
        bus.fill_instr = 32'h0D0D_0D0D;
        #1 chk("l1_waddr", 32'(bus.bram_waddr), 32'd0);
        @(negedge clk);
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
        #1 chk("l1_len", 32'(bus.loop_len), 32'd1);
        bus.replay_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("l1_instr", bus.replay_instr, 32'h0D0D_0D0D);
            chk("l1_wrap", 32'(bus.replay_wrap), 32'd1);
            chk("l1_raddr", 32'(bus.bram_raddr), 32'd0);
            @(negedge clk);
        end
        #1 chk("l1_iter", 32'(bus.iter_cnt), 32'd3);

        // Asynchronous reset in the middle of replay
        reset_n = 1'b0;
        #1;
        chk("ar_replay_valid", 32'(bus.replay_valid), 32'd0);
        chk("ar_loop_valid", 32'(bus.loop_valid), 32'd0);
        chk("ar_re", 32'(bus.bram_re), 32'd0);
        chk("ar_iter", 32'(bus.iter_cnt), 32'd0);
        chk("ar_len", 32'(bus.loop_len), 32'd0);
        chk("ar_wrap", 32'(bus.replay_wrap), 32'd0);
        bus.replay_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_last  = 1'b1;
        bus.fill_instr = 32'h0E0E_0E0E;
        #1 chk("ar_refill_we", 32'(bus.bram_we), 32'd1);
        @(negedge clk);
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
        #1;
        chk("ar_refill_valid", 32'(bus.loop_valid), 32'd1);
        chk("ar_refill_len", 32'(bus.loop_len), 32'd1);
        bus.replay_req = 1'b1;
        @(negedge clk);
        #1 chk("ar_refill_instr", bus.replay_instr, 32'h0E0E_0E0E);
        bus.replay_req = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
